// File: rtl/mod_cnt_pkg.sv
// Shared types for the modulo counter: boundary behaviour selector.
package cnt_pkg;
  typedef enum logic {CNT_WRAP = 1'b0, CNT_SAT = 1'b1} cnt_mode_t;
endpackage

// File: rtl/mod_cnt_if.sv
// Control and status bundle of the modulo counter; master drives controls, slave is the counter.
interface mod_cnt_if #(parameter int WIDTH = 8);
  import cnt_pkg::*;

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] step;
  cnt_mode_t        mode;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             bnd;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up, step, mode, ovf_clr,
    input  count, tc, bnd, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up, step, mode, ovf_clr,
    output count, tc, bnd, ovf
  );
endinterface

// File: rtl/mod_cnt_next.sv
// Next-count and boundary-event logic for one enabled counting step.
module mod_cnt_next
  import cnt_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             up_i,
  input  logic [WIDTH-1:0] step_i,
  input  cnt_mode_t        mode_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             evt_o
);
  localparam logic [WIDTH:0]   MOD_W = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH:0] cnt_x;
  logic [WIDTH:0] step_x;
  logic [WIDTH:0] step_m;
  logic [WIDTH:0] sum_x;

  // One extra bit keeps count+step and count+MODULUS exact before any compare.
  assign cnt_x  = {1'b0, count_i};
  assign step_x = {1'b0, step_i};
  assign step_m = step_x % MOD_W;
  assign sum_x  = cnt_x + step_x;

  always_comb begin
    nxt_o = count_i;
    evt_o = 1'b0;
    if (step_i == '0) begin
      nxt_o = count_i;
    end else if (up_i) begin
      if (sum_x < MOD_W) begin
        nxt_o = WIDTH'(sum_x);
      end else begin
        evt_o = 1'b1;
        if (mode_i == CNT_SAT) begin
          nxt_o = MAX_C;
        end else if (cnt_x + step_m >= MOD_W) begin
          nxt_o = WIDTH'(cnt_x + step_m - MOD_W);
        end else begin
          nxt_o = WIDTH'(cnt_x + step_m);
        end
      end
    end else begin
      if (step_x <= cnt_x) begin
        nxt_o = WIDTH'(cnt_x - step_x);
      end else begin
        evt_o = 1'b1;
        if (mode_i == CNT_SAT) begin
          nxt_o = '0;
        end else if (step_m <= cnt_x) begin
          nxt_o = WIDTH'(cnt_x - step_m);
        end else begin
          nxt_o = WIDTH'(cnt_x + MOD_W - step_m);
        end
      end
    end
  end
endmodule

// File: rtl/mod_cnt.sv
// Modulo up/down counter with wrap/saturate modes, boundary pulse and sticky overflow flag.
module mod_cnt
  import cnt_pkg::*;
#(
  parameter int     WIDTH   = 8,
  parameter longint MODULUS = longint'(1) << WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  mod_cnt_if.slave  bus
);
  localparam logic [WIDTH:0]   MOD_W = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("mod_cnt: WIDTH must be 2..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("mod_cnt: MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             bnd_q, ovf_q;
  logic [WIDTH-1:0] nxt;
  logic             evt;
  logic             evt_d;

  mod_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count_i (count_q),
    .up_i    (bus.up),
    .step_i  (bus.step),
    .mode_i  (bus.mode),
    .nxt_o   (nxt),
    .evt_o   (evt)
  );

  // clr and load win over en and never count as boundary events.
  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d = ({1'b0, bus.load_val} < MOD_W) ? bus.load_val : MAX_C;
    end else if (bus.en) begin
      count_d = nxt;
      evt_d   = evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      bnd_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bnd_q   <= evt_d;
      if (evt_d) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.bnd   = bnd_q;
  assign bus.ovf   = ovf_q;
  assign bus.tc    = bus.up ? (count_q == MAX_C) : (count_q == '0);
endmodule

// File: tb/tb_mod_cnt.sv
// Directed scoreboard bench for mod_cnt at WIDTH=4, MODULUS=10.
module tb_mod_cnt;
  import cnt_pkg::*;

  localparam int WIDTH = 4;

  typedef struct {
    logic [3:0] c;
    logic       b;
    logic       o;
    logic       t;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  mod_cnt_if #(.WIDTH(WIDTH)) bus ();

  mod_cnt #(.WIDTH(WIDTH), .MODULUS(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Drive one edge worth of controls at the falling edge and queue the expected result.
  task automatic vec(input logic c, input logic l, input logic [3:0] lv,
                     input logic e, input logic u, input logic [3:0] s,
                     input cnt_mode_t m, input logic oc,
                     input logic [3:0] ec, input logic eb, input logic eo, input logic et);
    exp_t x;
    @(negedge clk);
    bus.clr = c; bus.load = l; bus.load_val = lv; bus.en = e;
    bus.up = u; bus.step = s; bus.mode = m; bus.ovf_clr = oc;
    x.c = ec; x.b = eb; x.o = eo; x.t = et;
    exp_q.push_back(x);
  endtask

  // Monitor: one observation per rising edge while expectations are pending.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        n_txn++;
        chk($sformatf("txn%0d count", n_txn), 32'(bus.count), 32'(x.c));
        chk($sformatf("txn%0d bnd", n_txn), 32'(bus.bnd), 32'(x.b));
        chk($sformatf("txn%0d ovf", n_txn), 32'(bus.ovf), 32'(x.o));
        chk($sformatf("txn%0d tc", n_txn), 32'(bus.tc), 32'(x.t));
        $display("txn %0d: count=%0d bnd=%0b ovf=%0b tc=%0b (exp %0d %0b %0b %0b)",
                 n_txn, bus.count, bus.bnd, bus.ovf, bus.tc, x.c, x.b, x.o, x.t);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 4'd0; bus.en = 1'b0;
    bus.up = 1'b0; bus.step = 4'd0; bus.mode = CNT_WRAP; bus.ovf_clr = 1'b0;
    #3;
    chk("reset count", 32'(bus.count), 0);
    chk("reset bnd", 32'(bus.bnd), 0);
    chk("reset ovf", 32'(bus.ovf), 0);
    chk("reset tc", 32'(bus.tc), 1);
    #9 rst_n = 1'b1;

    // Wrap counting by 1 through 9 -> 0.
    for (int k = 1; k <= 12; k++)
      vec(0, 0, 0, 1, 1, 1, CNT_WRAP, 0, 4'(k % 10), k == 10, k >= 10, (k % 10) == 9);

    // Clamped load then saturation, bnd every edge.
    vec(0, 1, 13, 0, 1, 0, CNT_WRAP, 0, 9, 0, 1, 1);
    vec(0, 0, 0, 1, 1, 4, CNT_SAT, 0, 9, 1, 1, 1);
    vec(0, 0, 0, 1, 1, 4, CNT_SAT, 0, 9, 1, 1, 1);
    vec(0, 0, 0, 1, 1, 4, CNT_SAT, 0, 9, 1, 1, 1);

    // Down past zero: wrap and saturate.
    vec(0, 1, 2, 0, 0, 0, CNT_WRAP, 0, 2, 0, 1, 0);
    vec(0, 0, 0, 1, 0, 5, CNT_WRAP, 0, 7, 1, 1, 0);
    vec(0, 1, 2, 0, 0, 0, CNT_WRAP, 0, 2, 0, 1, 0);
    vec(0, 0, 0, 1, 0, 5, CNT_SAT, 0, 0, 1, 1, 1);

    // Priority clr > load > en.
    vec(0, 1, 5, 0, 1, 0, CNT_WRAP, 0, 5, 0, 1, 0);
    vec(1, 1, 3, 1, 1, 1, CNT_WRAP, 0, 0, 0, 1, 0);
    vec(0, 1, 5, 0, 1, 0, CNT_WRAP, 0, 5, 0, 1, 0);
    vec(0, 1, 3, 1, 1, 1, CNT_WRAP, 0, 3, 0, 1, 0);

    // step=0 holds; oversized steps reduced modulo 10.
    vec(0, 0, 0, 1, 1, 0, CNT_WRAP, 0, 3, 0, 1, 0);
    vec(0, 0, 0, 1, 0, 13, CNT_WRAP, 0, 0, 1, 1, 1);
    vec(0, 0, 0, 1, 1, 12, CNT_WRAP, 0, 2, 1, 1, 0);

    // Sticky ovf: set beats clear, then clear alone.
    vec(0, 1, 9, 0, 1, 0, CNT_WRAP, 0, 9, 0, 1, 1);
    vec(0, 0, 0, 1, 1, 1, CNT_WRAP, 1, 0, 1, 1, 0);
    vec(0, 0, 0, 0, 1, 0, CNT_WRAP, 1, 0, 0, 0, 0);
    vec(0, 0, 0, 0, 1, 0, CNT_WRAP, 0, 0, 0, 0, 0);

    // Asynchronous reset pulse between edges with bnd and ovf set.
    vec(0, 1, 9, 0, 1, 0, CNT_WRAP, 0, 9, 0, 0, 1);
    vec(0, 0, 0, 1, 1, 3, CNT_WRAP, 0, 2, 1, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst count", 32'(bus.count), 0);
    chk("async rst bnd", 32'(bus.bnd), 0);
    chk("async rst ovf", 32'(bus.ovf), 0);
    chk("async rst tc", 32'(bus.tc), 0);
    #1 rst_n = 1'b1;
    vec(0, 0, 0, 1, 1, 1, CNT_WRAP, 0, 1, 0, 0, 0);
    vec(0, 0, 0, 1, 1, 1, CNT_WRAP, 0, 2, 0, 0, 0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_cnt.md
MOD_CNT -- requirements
Module: mod_cnt

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning count register width in bits (legal 2..32).
REQ-002 The module SHALL have parameter MODULUS, default 2**WIDTH, meaning count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The module SHALL have port clr, input, 1, synchronous clear of count.
REQ-006 The module SHALL have port load, input, 1, synchronous load of load_val.
REQ-007 The module SHALL have port load_val, input, WIDTH, value to load.
REQ-008 The module SHALL have port en, input, 1, count enable.
REQ-009 The module SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-010 The module SHALL have port step, input, WIDTH, increment/decrement magnitude.
REQ-011 The module SHALL have port mode, input, cnt_mode_t, boundary mode: CNT_WRAP or CNT_SAT.
REQ-012 The module SHALL have port ovf_clr, input, 1, clears sticky ovf.
REQ-013 The module SHALL have port count, output, WIDTH, registered count value.
REQ-014 The module SHALL have port tc, output, 1, combinational terminal count: count==MODULUS-1 when up=1, count==0 when up=0.
REQ-015 The module SHALL have port bnd, output, 1, registered one-cycle pulse marking a boundary event on the previous edge.
REQ-016 The module SHALL have port ovf, output, 1, sticky boundary-event flag.

Function
REQ-017 Priority per edge SHALL be clr > load > en; with none asserted, count holds.
REQ-018 clr SHALL set count to 0 and SHALL NOT generate bnd.
REQ-019 load SHALL set count to load_val when load_val < MODULUS, else to MODULUS-1; load SHALL NOT generate bnd.
REQ-020 en with up=1 SHALL compute sum = count + step in WIDTH+1 bits with no truncation before the compare.
REQ-021 Up, sum <= MODULUS-1: count <= sum, no boundary event.
REQ-022 Up, sum >= MODULUS, CNT_WRAP: count <= sum - MODULUS (step < MODULUS); step >= MODULUS SHALL be reduced modulo MODULUS first; boundary event.
REQ-023 Up, sum >= MODULUS, CNT_SAT: count <= MODULUS-1; boundary event unless count was already MODULUS-1 with step=0.
REQ-024 en with up=0 and step <= count: count <= count - step, no boundary event.
REQ-025 Down, step > count, CNT_WRAP: count <= count + MODULUS - (step mod MODULUS); boundary event.
REQ-026 Down, step > count, CNT_SAT: count <= 0; boundary event.
REQ-027 step=0 SHALL hold count with no boundary event.
REQ-028 bnd SHALL be 1 for exactly the cycle after each boundary-event edge, else 0; back-to-back events give consecutive 1s.
REQ-029 ovf SHALL set on a boundary event and clear on ovf_clr; a simultaneous set and clear SHALL leave ovf=1.
REQ-030 A mode or up change SHALL take effect on the same edge it is sampled, with no pipeline latency.

Reset
REQ-031 rst_n low SHALL immediately force count=0, bnd=0, ovf=0, independent of clk.
REQ-032 Deassertion of rst_n mid-operation SHALL resume from count=0 on the first subsequent edge; no in-flight event survives.
REQ-033 tc during reset SHALL reflect count=0 (1 when up=0).

Structure
REQ-034 Package cnt_pkg SHALL hold typedef enum cnt_mode_t {CNT_WRAP, CNT_SAT}.
REQ-035 Combinational next-value and boundary-event logic SHALL live in sub-module mod_cnt_next, parametrised by WIDTH and MODULUS; mod_cnt holds the registers and priority mux.
REQ-036 Elaboration SHALL fail if MODULUS > 2**WIDTH or MODULUS < 2.

Verification (WIDTH=4, MODULUS=10)
REQ-037 Reset, then en=1, up=1, step=1, CNT_WRAP for 12 edges -> count 1..9,0,1,2; bnd=1 for one cycle after 9->0; ovf=1.
REQ-038 load_val=13, load=1 -> count=9; then en=1, up=1, step=4, CNT_SAT -> count stays 9, bnd pulses each edge.
REQ-039 count=2, up=0, step=5, CNT_WRAP -> count=7, bnd=1 next cycle; CNT_SAT from count=2 -> count=0.
REQ-040 clr, load, en all asserted at count=5, load_val=3 -> count=0, bnd=0; load+en only -> count=3.
REQ-041 ovf=1; ovf_clr=1 on the same edge as a wrap -> ovf stays 1; ovf_clr alone next edge -> ovf=0.
REQ-042 rst_n pulsed low mid-count between edges -> count=0, bnd=0, ovf=0 immediately; counting resumes at 1 on the first edge after release.
